// File: rtl/gcd_dispatch.sv
// gcd_dispatch: operand-pair FIFO feeding an external GCD core. Zero pairs are
// resolved locally, the core is given a bounded time to answer, and one
// result at a time is held for the consumer.
module gcd_dispatch #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned DEPTH   = 4,   // power of two, at least 2
  parameter int unsigned TIMEOUT = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             core_start,
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  input  logic             core_done,
  input  logic [WIDTH-1:0] core_res,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_err,
  output logic             busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_e;

  state_e             state_q;
  logic [2*WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [TW-1:0]      wait_cnt_q;
  logic [WIDTH-1:0]   op_a_q, op_b_q;
  logic [WIDTH-1:0]   out_res_q;
  logic               out_err_q;
  logic               out_valid_q;
  logic               core_start_q;
  logic               push, pop;
  logic [2*WIDTH-1:0] head;
  logic [WIDTH-1:0]   head_a, head_b;

  // Full is judged on the registered count only, so a full FIFO never
  // accepts even when a pop happens in the same cycle.
  assign in_ready = (count_q < CW'(DEPTH));
  assign push     = in_valid && in_ready;
  assign pop      = (state_q == IDLE) && (count_q != '0);
  assign head     = mem_q[rd_ptr_q];
  assign head_a   = head[2*WIDTH-1:WIDTH];
  assign head_b   = head[WIDTH-1:0];

  // Next pointer and occupancy values; push+pop together leaves count alone.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents are don't-care while count says empty.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_a, in_b};
  end

  // FIFO pointers and count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Dispatch FSM: pop, bypass or issue, wait with timeout, hold for consumer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= IDLE;
      op_a_q       <= '0;
      op_b_q       <= '0;
      core_start_q <= 1'b0;
      wait_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_res_q    <= '0;
      out_err_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop) begin
            op_a_q <= head_a;
            op_b_q <= head_b;
            if (head_a == '0 || head_b == '0) begin
              // gcd(x,0) = x; (0,0) has no gcd and is flagged.
              state_q     <= HOLD;
              out_valid_q <= 1'b1;
              out_res_q   <= head_a | head_b;
              out_err_q   <= (head_a == '0) && (head_b == '0);
            end else begin
              state_q      <= ISSUE;
              core_start_q <= 1'b1;
            end
          end
        end
        ISSUE: begin
          core_start_q <= 1'b0;
          wait_cnt_q   <= '0;
          state_q      <= WAIT;
        end
        WAIT: begin
          wait_cnt_q <= wait_cnt_q + TW'(1);
          if (core_done) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_res_q   <= core_res;
            out_err_q   <= 1'b0;
          end else if (wait_cnt_q == TW'(TIMEOUT - 1)) begin
            state_q     <= HOLD;
            out_valid_q <= 1'b1;
            out_res_q   <= '0;
            out_err_q   <= 1'b1;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Operand registers double as core operands and the result echo.
  assign core_start = core_start_q;
  assign core_a     = op_a_q;
  assign core_b     = op_b_q;
  assign out_valid  = out_valid_q;
  assign out_res    = out_res_q;
  assign out_a      = op_a_q;
  assign out_b      = op_b_q;
  assign out_err    = out_err_q;
  assign busy       = (state_q != IDLE) || (count_q != '0);

endmodule

// File: tb/tb_gcd_dispatch.sv
// Directed bench for gcd_dispatch with a behavioural GCD core model.
module tb_gcd_dispatch;

  localparam int unsigned WIDTH   = 4;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a, in_b;
  logic             core_start;
  logic [WIDTH-1:0] core_a, core_b;
  logic             core_done;
  logic [WIDTH-1:0] core_res;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_res, out_a, out_b;
  logic             out_err;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // core model state
  int         core_delay = 5;   // 0 = never answers
  int         cd_cnt = 0;
  logic       cd_pend = 1'b0;
  logic [WIDTH-1:0] cap_a = '0, cap_b = '0;
  int         start_cnt = 0;
  logic [WIDTH-1:0] last_a = '0, last_b = '0;

  gcd_dispatch #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .core_start(core_start), .core_a(core_a), .core_b(core_b),
    .core_done(core_done), .core_res(core_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_res(out_res), .out_a(out_a), .out_b(out_b), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] gcd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] x, y, t;
    x = a; y = b;
    while (y != '0) begin t = x % y; x = y; y = t; end
    return x;
  endfunction

  // GCD core: answers core_delay cycles after seeing core_start, one-cycle pulse.
  always @(posedge clk) begin
    #2;
    core_done = 1'b0;
    if (!rst) begin
      cd_pend = 1'b0;
    end else begin
      if (cd_pend) begin
        if (cd_cnt <= 1) begin
          core_done = 1'b1;
          core_res  = gcd(cap_a, cap_b);
          cd_pend   = 1'b0;
        end else begin
          cd_cnt = cd_cnt - 1;
        end
      end
      if (core_start) begin
        start_cnt = start_cnt + 1;
        last_a = core_a;
        last_b = core_b;
        cap_a  = core_a;
        cap_b  = core_b;
        if (core_delay > 0) begin
          cd_pend = 1'b1;
          cd_cnt  = core_delay;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Advance until out_valid is seen (bounded); reports cycles taken.
  task automatic wait_out(input string tag, input int budget, output int cycles);
    cycles = 0;
    do begin
      tick(1);
      cycles++;
    end while (!out_valid && cycles < budget);
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
  endtask

  task automatic expect_res(input string tag, input int res, input int a, input int b, input int err);
    check({tag, "_res"}, 32'(out_res), 32'(res));
    check({tag, "_a"},   32'(out_a),   32'(a));
    check({tag, "_b"},   32'(out_b),   32'(b));
    check({tag, "_err"}, 32'(out_err), 32'(err));
  endtask

  int cyc;
  int s0;
  int vcount;

  initial begin
    rst = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b0;
    core_done = 1'b0; core_res = '0;
    tick(3);
    // reset values
    check("rst_out_valid",  32'(out_valid),  32'd0);
    check("rst_core_start", 32'(core_start), 32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_out_res",    32'(out_res),    32'd0);
    check("rst_core_a",     32'(core_a),     32'd0);
    check("rst_out_err",    32'(out_err),    32'd0);
    rst = 1'b1;
    tick(1);
    check("rel_in_ready", 32'(in_ready), 32'd1);

    // (12,8) -> 4, core answers after 5 cycles
    core_delay = 5;
    in_valid = 1'b1; in_a = 4'd12; in_b = 4'd8;
    tick(1);
    in_valid = 1'b0;
    check("t1_c1_start", 32'(core_start), 32'd0);
    check("t1_c1_busy",  32'(busy),       32'd1);
    tick(1);
    check("t1_start",   32'(core_start), 32'd1);
    check("t1_core_a",  32'(core_a),     32'd12);
    check("t1_core_b",  32'(core_b),     32'd8);
    tick(1);
    check("t1_start_drop", 32'(core_start), 32'd0);
    tick(4);
    check("t1_not_yet",    32'(out_valid), 32'd0);
    check("t1_core_a_stable", 32'(core_a), 32'd12);
    tick(1);
    check("t1_valid", 32'(out_valid), 32'd1);
    expect_res("t1", 4, 12, 8, 0);
    check("t1_starts", 32'(start_cnt), 32'd1);
    tick(2);
    check("t1_hold_valid", 32'(out_valid), 32'd1);
    check("t1_hold_res",   32'(out_res),   32'd4);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    check("t1_valid_drop", 32'(out_valid), 32'd0);
    check("t1_idle_busy",  32'(busy),      32'd0);

    // zero bypass: (0,0) then (9,0)
    in_valid = 1'b1; in_a = 4'd0; in_b = 4'd0;
    tick(1);
    in_a = 4'd9; in_b = 4'd0;
    tick(1);
    in_valid = 1'b0;
    check("t2_lat_valid", 32'(out_valid), 32'd1);
    expect_res("t2_zz", 0, 0, 0, 1);
    out_ready = 1'b1;
    wait_out("t2_second", 10, cyc);
    out_ready = 1'b0;
    expect_res("t2_x0", 9, 9, 0, 0);
    tick(1);
    check("t2_no_start", 32'(start_cnt), 32'd1);
    out_ready = 1'b1;
    tick(2);
    out_ready = 1'b0;

    // back-pressure: out_ready=0, core immediate, 6 pairs offered
    core_delay = 1;
    in_valid = 1'b1; in_a = 4'd12; in_b = 4'd8;  tick(1);
    check("t3_rdy1", 32'(in_ready), 32'd1);
    in_a = 4'd9;  in_b = 4'd6;  tick(1);
    check("t3_rdy2", 32'(in_ready), 32'd1);
    in_a = 4'd15; in_b = 4'd5;  tick(1);
    check("t3_rdy3", 32'(in_ready), 32'd1);
    in_a = 4'd7;  in_b = 4'd3;  tick(1);
    check("t3_rdy4", 32'(in_ready), 32'd1);
    in_a = 4'd14; in_b = 4'd10; tick(1);
    check("t3_full", 32'(in_ready), 32'd0);
    in_a = 4'd6;  in_b = 4'd4;  tick(1);
    in_valid = 1'b0;
    check("t3_full_held", 32'(in_ready), 32'd0);
    check("t3_first_valid", 32'(out_valid), 32'd1);
    expect_res("t3_p1", 4, 12, 8, 0);
    out_ready = 1'b1;
    wait_out("t3_p2", 20, cyc); expect_res("t3_p2", 3, 9, 6, 0);
    wait_out("t3_p3", 20, cyc); expect_res("t3_p3", 5, 15, 5, 0);
    wait_out("t3_p4", 20, cyc); expect_res("t3_p4", 1, 7, 3, 0);
    wait_out("t3_p5", 20, cyc); expect_res("t3_p5", 2, 14, 10, 0);
    vcount = 0;
    repeat (12) begin tick(1); if (out_valid) vcount++; end
    check("t3_no_sixth", 32'(vcount), 32'd0);
    check("t3_busy", 32'(busy), 32'd0);
    out_ready = 1'b0;

    // timeout: core never answers, next queued job proceeds
    core_delay = 0;
    in_valid = 1'b1; in_a = 4'd10; in_b = 4'd4; tick(1);
    in_a = 4'd8; in_b = 4'd12; tick(1);
    in_valid = 1'b0;
    check("t4_start", 32'(core_start), 32'd1);
    wait_out("t4_timeout", 40, cyc);
    check("t4_latency", 32'(cyc), 32'(TIMEOUT + 1));
    expect_res("t4_to", 0, 10, 4, 1);
    core_delay = 3;
    out_ready = 1'b1;
    wait_out("t4_next", 20, cyc);
    expect_res("t4_next", 4, 8, 12, 0);
    tick(2);
    out_ready = 1'b0;

    // reset during WAIT with two entries queued
    core_delay = 0;
    in_valid = 1'b1; in_a = 4'd12; in_b = 4'd8; tick(1);
    in_a = 4'd9;  in_b = 4'd6; tick(1);
    in_a = 4'd15; in_b = 4'd5; tick(1);
    in_valid = 1'b0;
    tick(2);
    s0 = start_cnt;
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    check("t5_valid",  32'(out_valid),  32'd0);
    check("t5_start",  32'(core_start), 32'd0);
    check("t5_busy",   32'(busy),       32'd0);
    check("t5_ready",  32'(in_ready),   32'd1);
    check("t5_core_a", 32'(core_a),     32'd0);
    check("t5_res",    32'(out_res),    32'd0);
    out_ready = 1'b1;
    vcount = 0;
    repeat (40) begin tick(1); if (out_valid) vcount++; end
    check("t5_no_valid", 32'(vcount), 32'd0);
    check("t5_no_start", 32'(start_cnt), 32'(s0));
    core_delay = 2;
    in_valid = 1'b1; in_a = 4'd15; in_b = 4'd10; tick(1);
    in_valid = 1'b0;
    wait_out("t5_fresh", 20, cyc);
    expect_res("t5_fresh", 5, 15, 10, 0);
    tick(2);
    out_ready = 1'b0;

    // simultaneous push and pop at count = DEPTH-1
    core_delay = 1;
    in_valid = 1'b1; in_a = 4'd4;  in_b = 4'd6;  tick(1);
    in_a = 4'd15; in_b = 4'd3;  tick(1);
    in_a = 4'd8;  in_b = 4'd0;  tick(1);
    in_a = 4'd10; in_b = 4'd15; tick(1);
    in_valid = 1'b0;
    check("t6_p1_valid", 32'(out_valid), 32'd1);
    expect_res("t6_p1", 2, 4, 6, 0);
    out_ready = 1'b1;
    tick(1);
    check("t6_idle_valid", 32'(out_valid), 32'd0);
    check("t6_rdy_before", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_a = 4'd9; in_b = 4'd12; tick(1);
    check("t6_rdy_after_pp", 32'(in_ready), 32'd1);
    in_a = 4'd14; in_b = 4'd7; tick(1);
    in_valid = 1'b0;
    check("t6_full", 32'(in_ready), 32'd0);
    wait_out("t6_p2", 20, cyc); expect_res("t6_p2", 3, 15, 3, 0);
    wait_out("t6_p3", 20, cyc); expect_res("t6_p3", 8, 8, 0, 0);
    wait_out("t6_p4", 20, cyc); expect_res("t6_p4", 5, 10, 15, 0);
    wait_out("t6_p5", 20, cyc); expect_res("t6_p5", 3, 9, 12, 0);
    wait_out("t6_p6", 20, cyc); expect_res("t6_p6", 7, 14, 7, 0);
    vcount = 0;
    repeat (10) begin tick(1); if (out_valid) vcount++; end
    check("t6_no_dup", 32'(vcount), 32'd0);
    check("t6_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
